// File: rtl/interleaver_blk_ctrl.sv
// Block sequencer for the turbo-coder interleaver: byte fill, buffer load, bit-index stream.
// Optional status outputs (blk_count, overrun) are built when INTLV_CTRL_STATUS_EN is defined.
`timescale 1ns/1ps

module interleaver_blk_ctrl #(
    parameter int K_SMALL = 1056,
    parameter int K_LARGE = 6144
) (
    input  logic        clock,
    input  logic        rst,
    input  logic        k_size_6144,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        shift_en,
    output logic        buf_load,
    output logic        k_out,
    output logic [13:0] bit_idx,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        blk_start,
    output logic        blk_end,
    output logic [15:0] blk_count,
    output logic        overrun
);

    localparam logic [9:0]  LAST_SMALL = 10'(K_SMALL / 8 - 1);
    localparam logic [9:0]  LAST_LARGE = 10'(K_LARGE / 8 - 1);
    localparam logic [13:0] END_SMALL  = 14'(K_SMALL - 1);
    localparam logic [13:0] END_LARGE  = 14'(K_LARGE - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [9:0]  byte_cnt;
    logic        full;
    logic        k_fill;
    logic        k_cur;
    logic        last_byte;
    logic        stream_free;
    logic        end_take;
    logic [13:0] idx_nx;
    logic        k_out_nx;

    // Fill side
    assign byte_ready = !full;
    assign shift_en   = byte_valid & byte_ready;
    // The size select only matters on the first byte of a block.
    assign k_cur      = (byte_cnt == '0) ? k_size_6144 : k_fill;
    assign last_byte  = byte_cnt == (k_cur ? LAST_LARGE : LAST_SMALL);

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            byte_cnt <= '0;
            full     <= 1'b0;
            k_fill   <= 1'b0;
        end else begin
            if (buf_load) begin
                full <= 1'b0;
            end
            if (shift_en) begin
                if (byte_cnt == '0) begin
                    k_fill <= k_size_6144;
                end
                if (last_byte) begin
                    byte_cnt <= '0;
                    full     <= 1'b1;
                end else begin
                    byte_cnt <= byte_cnt + 10'd1;
                end
            end
        end
    end

    // Stream side
    assign out_valid   = state == STREAM;
    assign blk_start   = out_valid & (bit_idx == '0);
    assign blk_end     = out_valid & (bit_idx == (k_out ? END_LARGE : END_SMALL));
    assign end_take    = blk_end & out_ready;
    assign stream_free = (state == IDLE) | end_take;
    assign buf_load    = full & stream_free;

    always_comb begin
        state_nx = state;
        idx_nx   = bit_idx;
        k_out_nx = k_out;
        if (buf_load) begin
            state_nx = STREAM;
            idx_nx   = '0;
            k_out_nx = k_fill;
        end else if (end_take) begin
            state_nx = IDLE;
            idx_nx   = '0;
        end else if (out_valid && out_ready) begin
            idx_nx = bit_idx + 14'd1;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bit_idx <= '0;
            k_out   <= 1'b0;
        end else begin
            state   <= state_nx;
            bit_idx <= idx_nx;
            k_out   <= k_out_nx;
        end
    end

`ifdef INTLV_CTRL_STATUS_EN
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            blk_count <= '0;
            overrun   <= 1'b0;
        end else begin
            if (end_take) begin
                blk_count <= blk_count + 16'd1;
            end
            if (byte_valid && !byte_ready) begin
                overrun <= 1'b1;
            end
        end
    end
`else
    assign blk_count = '0;
    assign overrun   = 1'b0;
`endif

endmodule

// File: tb/tb_interleaver_blk_ctrl.sv
// Randomised self-checking bench for interleaver_blk_ctrl.
// A block-level model (byte counts, full buffer, stream position) predicts every output.
`timescale 1ns/1ps

module tb_interleaver_blk_ctrl;

`ifdef INTLV_CTRL_STATUS_EN
    localparam bit STATUS = 1'b1;
`else
    localparam bit STATUS = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        rst = 1'b1;
    logic        k_size_6144 = 1'b0;
    logic        byte_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic        byte_ready;
    logic        shift_en;
    logic        buf_load;
    logic        k_out;
    logic [13:0] bit_idx;
    logic        out_valid;
    logic        blk_start;
    logic        blk_end;
    logic [15:0] blk_count;
    logic        overrun;

    int n_checks = 0;
    int n_fail = 0;

    // Model state: bytes of the filling block, buffered block, streaming block.
    int m_bytes;
    int m_kfill;
    int m_bufk;
    int m_k;
    int m_idx;
    int m_cnt;
    bit m_full;
    bit m_stream;
    bit m_kout;
    bit m_ovr;

    bit          e_shift;
    bit          e_end;
    bit          e_load;
    logic [37:0] exp_v;

    localparam logic [37:0] RST_V = {1'b1, 37'b0};

    interleaver_blk_ctrl dut (
        .clock       (clock),
        .rst         (rst),
        .k_size_6144 (k_size_6144),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .shift_en    (shift_en),
        .buf_load    (buf_load),
        .k_out       (k_out),
        .bit_idx     (bit_idx),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .blk_start   (blk_start),
        .blk_end     (blk_end),
        .blk_count   (blk_count),
        .overrun     (overrun)
    );

    always #5 clock = ~clock;

    function automatic logic [37:0] act_v();
        return {byte_ready, shift_en, buf_load, k_out, bit_idx, out_valid,
                blk_start, blk_end, blk_count, overrun};
    endfunction

    task automatic model_reset();
        m_bytes = 0; m_kfill = 0; m_bufk = 0; m_k = 0; m_idx = 0;
        m_cnt = 0; m_full = 0; m_stream = 0; m_kout = 0; m_ovr = 0;
    endtask

    // Drive one cycle of inputs and predict the outputs for that cycle.
    task automatic step(input bit bv, input bit ks, input bit ordy);
        @(negedge clock);
        byte_valid = bv;
        k_size_6144 = ks;
        out_ready = ordy;
        #1;
        e_shift = bv && !m_full;
        e_end = m_stream && (m_idx == m_k - 1);
        e_load = m_full && (!m_stream || (e_end && ordy));
        exp_v = {!m_full, e_shift, e_load, m_kout,
                 m_stream ? 14'(m_idx) : 14'd0, m_stream,
                 m_stream && (m_idx == 0), e_end,
                 STATUS ? 16'(m_cnt) : 16'd0, STATUS ? m_ovr : 1'b0};
    endtask

    // Apply the block rules for the clock edge that follows the step.
    task automatic advance();
        bit ends;
        ends = e_end && out_ready;
        if (ends) m_cnt = (m_cnt + 1) % 65536;
        if (byte_valid && m_full) m_ovr = 1;
        if (e_load) begin
            m_full = 0;
            m_stream = 1;
            m_idx = 0;
            m_k = m_bufk;
            m_kout = (m_bufk == 6144);
        end else if (ends) begin
            m_stream = 0;
            m_idx = 0;
        end else if (m_stream && out_ready) begin
            m_idx++;
        end
        if (e_shift) begin
            if (m_bytes == 0) m_kfill = k_size_6144 ? 6144 : 1056;
            m_bytes++;
            if (m_bytes * 8 == m_kfill) begin
                m_bytes = 0;
                m_full = 1;
                m_bufk = m_kfill;
            end
        end
    endtask

    task automatic do_async_reset(input string tag);
        @(posedge clock);
        #2;
        rst = 1'b1;
        byte_valid = 1'b0;
        #1;
        n_checks++;
        if (act_v() !== RST_V) begin
            n_fail++;
            $display("FAIL %s async: got=%h exp=%h", tag, act_v(), RST_V);
        end
        model_reset();
        @(negedge clock);
        @(negedge clock);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clock);
        #1;
        n_checks++;
        if (act_v() !== RST_V) begin
            n_fail++;
            $display("FAIL reset_vals: got=%h exp=%h", act_v(), RST_V);
        end
        @(negedge clock);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_small_block();
        int acc = 0, shifts = 0, loads = 0, starts = 0, ends = 0, valids = 0;
        int last_byte_cyc = -1, load_cyc = -1;
        bit done = 0;
        for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
            step(acc < 132, 1'b0, 1'b1);
            n_checks++;
            if (act_v() !== exp_v) begin
                n_fail++;
                $display("FAIL small cyc=%0d got=%h exp=%h", cyc, act_v(), exp_v);
            end
            if (shift_en) begin shifts++; last_byte_cyc = cyc; end
            if (buf_load) begin loads++; load_cyc = cyc; end
            if (blk_start) starts++;
            if (blk_end) ends++;
            if (out_valid) valids++;
            if (e_shift) acc++;
            advance();
            done = (acc == 132) && (starts > 0) && !m_stream && !m_full;
        end
        n_checks++;
        if (!done) begin n_fail++; $display("FAIL small_timeout: done=%0d exp=1", done); end
        n_checks++;
        if (shifts != 132) begin n_fail++; $display("FAIL small_shifts: got=%0d exp=132", shifts); end
        n_checks++;
        if (loads != 1 || load_cyc != last_byte_cyc + 1) begin
            n_fail++;
            $display("FAIL small_load: n=%0d at=%0d exp n=1 at=%0d", loads, load_cyc, last_byte_cyc + 1);
        end
        n_checks++;
        if (starts != 1 || ends != 1 || valids != 1056) begin
            n_fail++;
            $display("FAIL small_stream: st=%0d en=%0d v=%0d exp 1 1 1056", starts, ends, valids);
        end
    endtask

    task automatic test_back_to_back();
        int acc = 0, starts = 0, coinc = 0, rdy_low = 0, valids = 0;
        int first_start = -1, last_end = -1;
        bit done = 0;
        for (int cyc = 0; cyc < 16000 && !done; cyc++) begin
            step(acc < 1536, 1'b1, 1'b1);
            n_checks++;
            if (act_v() !== exp_v) begin
                n_fail++;
                $display("FAIL b2b cyc=%0d got=%h exp=%h", cyc, act_v(), exp_v);
            end
            if (buf_load && blk_end) coinc++;
            if (blk_start) begin starts++; if (first_start < 0) first_start = cyc; end
            if (blk_end) last_end = cyc;
            if (!byte_ready) rdy_low++;
            if (out_valid) valids++;
            if (e_shift) acc++;
            advance();
            done = (starts == 2) && !m_stream && !m_full;
        end
        n_checks++;
        if (!done) begin n_fail++; $display("FAIL b2b_timeout: done=%0d exp=1", done); end
        n_checks++;
        if (coinc != 1) begin n_fail++; $display("FAIL b2b_coinc: got=%0d exp=1", coinc); end
        n_checks++;
        if (valids != 12288 || last_end - first_start + 1 != 12288) begin
            n_fail++;
            $display("FAIL b2b_gapless: v=%0d span=%0d exp 12288", valids, last_end - first_start + 1);
        end
        n_checks++;
        if (rdy_low < 1000) begin n_fail++; $display("FAIL b2b_rdy_low: got=%0d exp>=1000", rdy_low); end
    endtask

    task automatic test_k_toggle();
        int acc = 0, starts = 0, valids = 0, acc_at_load = -1;
        bit k_at_start = 0;
        bit done = 0;
        for (int cyc = 0; cyc < 9000 && !done; cyc++) begin
            step(acc < 768, acc < 10, 1'b1);
            n_checks++;
            if (act_v() !== exp_v) begin
                n_fail++;
                $display("FAIL ktog cyc=%0d got=%h exp=%h", cyc, act_v(), exp_v);
            end
            if (buf_load && acc_at_load < 0) acc_at_load = acc;
            if (blk_start) begin starts++; k_at_start = k_out; end
            if (out_valid) valids++;
            if (e_shift) acc++;
            advance();
            done = (starts == 1) && !m_stream && !m_full;
        end
        n_checks++;
        if (!done || acc_at_load != 768) begin
            n_fail++;
            $display("FAIL ktog_bytes: at_load=%0d exp=768", acc_at_load);
        end
        n_checks++;
        if (k_at_start !== 1'b1 || valids != 6144) begin
            n_fail++;
            $display("FAIL ktog_kout: k=%0d v=%0d exp 1 6144", k_at_start, valids);
        end
    endtask

    task automatic test_stall();
        int acc = 0, st100 = 0, stend = 0, starts = 0, loads = 0;
        int at100 = 0, end_cycs = 0, bad_load = 0;
        bit hold;
        bit done = 0;
        for (int cyc = 0; cyc < 5000 && !done; cyc++) begin
            hold = m_stream && ((m_idx == 100 && st100 < 5) || (m_idx == m_k - 1 && stend < 5));
            step(acc < 264, 1'b0, !hold);
            n_checks++;
            if (act_v() !== exp_v) begin
                n_fail++;
                $display("FAIL stall cyc=%0d got=%h exp=%h", cyc, act_v(), exp_v);
            end
            if (hold && m_idx == 100) st100++;
            else if (hold) stend++;
            if (out_valid && bit_idx == 14'd100) at100++;
            if (blk_end) end_cycs++;
            if (buf_load && blk_end && !out_ready) bad_load++;
            if (buf_load) loads++;
            if (blk_start && bit_idx == 14'd0 && !hold) starts += 0;
            if (e_load) begin st100 = 0; stend = 0; starts++; end
            if (e_shift) acc++;
            advance();
            done = (starts == 2) && !m_stream && !m_full;
        end
        n_checks++;
        if (!done) begin n_fail++; $display("FAIL stall_timeout: done=%0d exp=1", done); end
        n_checks++;
        if (at100 != 12 || end_cycs != 12) begin
            n_fail++;
            $display("FAIL stall_hold: at100=%0d end=%0d exp 12 12", at100, end_cycs);
        end
        n_checks++;
        if (bad_load != 0 || loads != 2) begin
            n_fail++;
            $display("FAIL stall_load: bad=%0d loads=%0d exp 0 2", bad_load, loads);
        end
    endtask

    task automatic test_reset_mid();
        int acc = 0, loads = 0, starts = 0;
        bit done = 0;
        for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
            step(acc < 132, 1'b0, 1'b1);
            n_checks++;
            if (act_v() !== exp_v) begin
                n_fail++;
                $display("FAIL rmid_a cyc=%0d got=%h exp=%h", cyc, act_v(), exp_v);
            end
            if (e_shift) acc++;
            advance();
            done = m_stream && m_idx == 500;
        end
        n_checks++;
        if (!done) begin n_fail++; $display("FAIL rmid_reach500: done=%0d exp=1", done); end
        do_async_reset("rst_stream");
        acc = 0;
        for (int cyc = 0; cyc < 200 && acc < 50; cyc++) begin
            step(1'b1, 1'b1, 1'b1);
            n_checks++;
            if (act_v() !== exp_v) begin
                n_fail++;
                $display("FAIL rmid_b cyc=%0d got=%h exp=%h", cyc, act_v(), exp_v);
            end
            if (e_shift) acc++;
            advance();
        end
        do_async_reset("rst_fill");
        acc = 0;
        for (int cyc = 0; cyc < 160; cyc++) begin
            step(acc < 131, 1'b0, 1'b1);
            n_checks++;
            if (act_v() !== exp_v) begin
                n_fail++;
                $display("FAIL rmid_c cyc=%0d got=%h exp=%h", cyc, act_v(), exp_v);
            end
            if (buf_load) loads++;
            if (e_shift) acc++;
            advance();
        end
        n_checks++;
        if (loads != 0) begin n_fail++; $display("FAIL rmid_noload: got=%0d exp=0", loads); end
        done = 0;
        for (int cyc = 0; cyc < 2000 && !done; cyc++) begin
            step(acc < 132, 1'b1, 1'b1);
            n_checks++;
            if (act_v() !== exp_v) begin
                n_fail++;
                $display("FAIL rmid_d cyc=%0d got=%h exp=%h", cyc, act_v(), exp_v);
            end
            if (buf_load) loads++;
            if (blk_start) starts++;
            if (e_shift) acc++;
            advance();
            done = (starts == 1) && !m_stream && !m_full;
        end
        n_checks++;
        if (!done || loads != 1) begin
            n_fail++;
            $display("FAIL rmid_refill: loads=%0d done=%0d exp 1 1", loads, done);
        end
    endtask

    task automatic test_random();
        int fills = 0;
        bit was_shift;
        bit done = 0;
        for (int cyc = 0; cyc < 40000 && !done; cyc++) begin
            step((fills < 3) && ($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
            n_checks++;
            if (act_v() !== exp_v) begin
                n_fail++;
                $display("FAIL rand cyc=%0d got=%h exp=%h", cyc, act_v(), exp_v);
            end
            was_shift = e_shift;
            advance();
            if (was_shift && m_bytes == 0) fills++;
            done = (fills == 3) && !m_full && !m_stream;
        end
        n_checks++;
        if (!done) begin n_fail++; $display("FAIL rand_timeout: fills=%0d exp=3", fills); end
    endtask

    task automatic test_status();
        int acc = 0, ends = 0;
        bit done = 0;
        do_async_reset("rst_status");
        for (int cyc = 0; cyc < 5000 && !done; cyc++) begin
            step(acc < 396 || cyc < 300, 1'b0, 1'b1);
            n_checks++;
            if (act_v() !== exp_v) begin
                n_fail++;
                $display("FAIL status cyc=%0d got=%h exp=%h", cyc, act_v(), exp_v);
            end
            if (blk_end && out_ready) ends++;
            if (e_shift) acc++;
            advance();
            done = (ends == 3) && !m_stream && !m_full;
        end
        repeat (5) begin
            step(1'b0, 1'b0, 1'b1);
            advance();
        end
        n_checks++;
        if (!done || blk_count !== (STATUS ? 16'd3 : 16'd0)) begin
            n_fail++;
            $display("FAIL status_count: got=%0d exp=%0d", blk_count, STATUS ? 3 : 0);
        end
        n_checks++;
        if (overrun !== STATUS) begin
            n_fail++;
            $display("FAIL status_overrun: got=%0b exp=%0b", overrun, STATUS);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_small_block();
        test_back_to_back();
        test_k_toggle();
        test_stall();
        test_reset_mid();
        test_random();
        test_status();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/interleaver_blk_ctrl.md
# interleaver_blk_ctrl

Block-level sequencer for the turbo-coder interleaver datapath. It accepts a byte stream through a valid/ready handshake and drives the input shift register's shift enable. It pulses the secondary-buffer load once a full block (K = 1056 or 6144 bits) has arrived, then generates the 14-bit bit index that selects the serial `ci`/`cpii` outputs for K cycles. The shift register and secondary buffer are separate, so the next block fills while the current block streams.

## Interface
Parameters:
- `K_SMALL`, 1056: small block size in bits.
- `K_LARGE`, 6144: large block size in bits.

Ports:
- `clock`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `k_size_6144`  in  1  block size select: 0 means K_SMALL, 1 means K_LARGE. Sampled on the first byte of each block.
- `byte_valid`  in  1  upstream byte available.
- `byte_ready`  out  1  controller can accept a byte.
- `shift_en`  out  1  shift register enable; equals `byte_valid & byte_ready`.
- `buf_load`  out  1  one-cycle load strobe to the secondary buffer (drives `ready_in`).
- `k_out`  out  1  block size of the block currently streaming (drives the remapper/index K select).
- `bit_idx`  out  14  mux index, 0..K-1.
- `out_valid`  out  1  `bit_idx` is valid; the serial outputs are meaningful.
- `out_ready`  in  1  downstream accepts the current bit.
- `blk_start`  out  1  `out_valid` and `bit_idx==0`.
- `blk_end`  out  1  `out_valid` and `bit_idx==K-1`.

## Operation
The fill side and the stream side run concurrently.

Fill side:
- State: 10-bit `byte_cnt`, `full` flag, and latched `k_fill`.
- `byte_ready = !full`.
- On each accepted byte, `byte_cnt` increments. On the first byte (`byte_cnt==0`), `k_fill` is latched from `k_size_6144`. Changes to `k_size_6144` mid-block are ignored.
- Bytes per block: 132 (K_SMALL/8) or 768 (K_LARGE/8).
- When the last byte is accepted, `byte_cnt` returns to 0 and `full` sets on the next edge.

Stream side:
- States: IDLE and STREAM.
- `stream_free = (state==IDLE) | (blk_end & out_ready)`.
- `buf_load = full & stream_free`. This is combinational from registered state.
- When `buf_load` is high:
  - `full` clears.
  - `k_out` is set from `k_fill`.
  - `bit_idx` is set to 0.
  - The state becomes STREAM on the next edge.
- In STREAM, `out_valid` is 1. `bit_idx` increments only when `out_ready` is high.
- When `blk_end & out_ready`:
  - If `buf_load` is also high, the state stays in STREAM with `bit_idx` 0 (back-to-back blocks).
  - Otherwise the state goes to IDLE.

Width rules:
- `bit_idx` is 14 bits and never exceeds K-1. There is no wrap past K-1.
- `byte_cnt` never exceeds 767.

## Timing
Reset values:
- `byte_ready` = 1 (comb. from `full`=0).
- `shift_en`, `buf_load`, `out_valid`, `blk_start`, `blk_end` = 0.
- `bit_idx` = 0, `k_out` = 0, state = IDLE, `byte_cnt` = 0.

Latency:
- Last byte accepted at cycle T.
- `full` is 1 at T+1. If the stream side is idle, `buf_load` is high at T+1.
- `out_valid` with `bit_idx` = 0 at T+2.
- `blk_end` at T+1+K when there are no stalls.
- `byte_ready` returns to 1 at T+2.

Boundary conditions:
- Buffer full while streaming: `byte_ready` stays 0 until the `buf_load` cycle, and is 1 from the next cycle.
- Last byte accepted in the same cycle as `blk_end & out_ready`: the stream goes IDLE, then `buf_load` fires at T+1.
- `out_ready` low on `blk_end`: `buf_load` is held off and `bit_idx` holds.
- `rst` mid-fill or mid-stream: all state clears immediately. The partial block is discarded and no `buf_load` is issued.

## Configuration
- `INTLV_CTRL_STATUS_EN`, when defined, adds two outputs:
  - `blk_count` [15:0]: increments on every `blk_end & out_ready`, wraps at 65535→0, resets to 0.
  - `overrun`: sticky; set when `byte_valid` is high while `byte_ready` is low; cleared only by `rst`.
- Without the macro, both ports exist but are tied to 0, and no counter or flag logic is built.

## Test plan
- K=1056, `out_ready`=1, reset then 132 bytes back-to-back:
  - `shift_en` is high 132 cycles.
  - `buf_load` is a single pulse 1 cycle after the last byte.
  - `bit_idx` runs 0..1055 over 1056 consecutive cycles, with `blk_start` and `blk_end` once each. The stream then returns to IDLE.
- K=6144 followed immediately by a second 6144 block:
  - `byte_ready` drops after byte 768.
  - Second `buf_load` is coincident with the first `blk_end`.
  - `bit_idx` goes 6143→0 with no gap.
- Toggle `k_size_6144` from 1 to 0 after byte 10 of a block: the block still takes 768 bytes and `k_out`=1 during its stream.
- Hold `out_ready` low for 5 cycles at `bit_idx`=100 and at `blk_end`: `bit_idx` holds 100, and `blk_end` stays high with no load until `out_ready` returns.
- Assert `rst` at `bit_idx`=500 and at byte 50:
  - All outputs return to reset values asynchronously.
  - The next block needs a full 132 or 768 bytes.
- With `INTLV_CTRL_STATUS_EN`: drive `byte_valid` while `full` → `overrun`=1 and sticky. `blk_count` equals 3 after three streamed blocks.
